mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin select generator that drives the select input of the team's N-to-1 multiplexers (3x1 by default). Arbitrates among N request lines and produces a registered select code plus valid flag. Holds each grant until the consumer acknowledges, the requester withdraws, or a hold timeout expires. Sits directly upstream of the mux select port; `sel` connects straight to the mux `S` input.

## Interface
- `N` — 3 — number of requesters / mux data inputs.
- `SELW` — 2 — select width; must satisfy N <= 2^SELW − 1.
- `HOLD_MAX` — 8 — maximum cycles a grant is held without ack (>= 2).
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `req` in N — request per mux input; bit i requests input i.
- `ack` in 1 — consumer has taken the current selected data; sampled only while `valid`=1.
- `sel` out SELW — registered select code; idle code = all ones (2'b11 for defaults).
- `valid` out 1 — `sel` addresses a granted input.
- `timeout` out 1 — one-cycle pulse when a grant is force-released.

## Operation
- States: IDLE, GRANT.
- Round-robin pointer `ptr` (0..N−1): search starts at `ptr`, wraps N−1 -> 0; first set `req` bit wins.
- IDLE: `valid`=0, `sel`=idle code. If any `req` set: load winner into `sel`, `valid`<=1, clear hold counter, -> GRANT.
- GRANT, release events (priority order): ack=1 -> normal release; else req[sel]=0 -> withdraw release; else hold counter = HOLD_MAX−1 -> forced release, `timeout`<=1 for one cycle.
- On any release: `ptr` <= (sel+1) mod N. Re-arbitrate in the same edge using the new pointer and current `req`: winner found -> stay GRANT, load new `sel`, clear counter (back-to-back, no bubble); none -> IDLE, `sel`<=idle code, `valid`<=0.
- Only requester active: it may be re-granted immediately after its own release (pointer wraps back to it).
- No release: `sel` stable, counter increments (saturates at HOLD_MAX−1).
- `req` changes on non-granted lines during GRANT have no effect until release.

## Timing
- Reset values: `sel`=idle code, `valid`=0, `timeout`=0, `ptr`=0, counter=0, state IDLE. Reset is asynchronous; asserting mid-grant drops `valid` immediately, no release recorded.
- Request-to-grant latency: 1 cycle (req sampled at edge k, `valid`/`sel` updated after edge k).
- Ack-to-next-grant: 0 bubble cycles when another request is pending.
- Forced release occurs on the edge ending the HOLD_MAX-th consecutive GRANT cycle without ack/withdraw; `timeout` high for the following cycle only.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package `mux_sel_pkg`: state enum (IDLE, GRANT), `SEL_IDLE` constant (all ones of SELW), pointer-increment-with-wrap function.
- Sub-module `rr_pick`: combinational pointer-rotated priority finder (inputs `req`, `ptr`; outputs `found`, `idx`). Instantiated once; used for both IDLE arbitration and release re-arbitration.
- Top holds FSM, pointer, hold counter, output registers.

## Test plan
- Reset: rst=1 mid-grant (sel=1, valid=1) -> sel=2'b11, valid=0, timeout=0 immediately, before next clk edge.
- Single request: req=3'b010 from IDLE -> next cycle sel=1, valid=1; ack=1 with req held -> sel=1 re-granted, valid stays 1.
- Rotation: req=3'b111, ack=1 every cycle from ptr=0 -> sel sequence 0,1,2,0, valid continuously 1.
- Wrap fairness: ptr=2, req=3'b011 -> grant sel=0, then on ack sel=1.
- Withdraw: grant sel=2, drop req[2], others 0 -> next cycle valid=0, sel=2'b11, timeout=0, ptr=0.
- Timeout: HOLD_MAX=8, req=3'b101, ack=0 held -> sel=0 for 8 cycles, then sel=2 with timeout=1 for exactly one cycle.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg
// Shared types and helpers for the mux select arbiter.
//   state_t   : arbiter FSM states (IDLE, GRANT)
//   MUX_*     : default configuration (3 requesters, 2-bit select, hold limit 8)
//   SEL_IDLE  : idle select code for the default select width (all ones)
//   ptr_inc() : round-robin pointer increment with wrap at n
package mux_sel_pkg;

    localparam int MUX_N        = 3;
    localparam int MUX_SELW     = 2;
    localparam int MUX_HOLD_MAX = 8;

    localparam logic [MUX_SELW-1:0] SEL_IDLE = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int ptr_inc(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority finder. Searches req_i starting at
// ptr_i, wrapping N-1 -> 0; the first set bit wins.
//   req_i   [N-1:0]    request vector
//   ptr_i   [SELW-1:0] search start position (0..N-1)
//   found_o            at least one request is set
//   idx_o   [SELW-1:0] winning index (0 when nothing found)
module rr_pick #(
    parameter int N    = 3,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            found_o,
    output logic [SELW-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             pos;

    // Doubling the vector and shifting by ptr puts req[(ptr+j) mod N] at bit j.
    assign dbl = {req_i, req_i};
    assign rot = N'(dbl >> ptr_i);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        // Walk from the far end so the lowest rotated offset is the last write.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pos = int'(ptr_i) + j;
                if (pos >= N) begin
                    pos = pos - N;
                end
                found_o = 1'b1;
                idx_o   = SELW'(pos);
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Round-robin select generator feeding the S input of an N-to-1 mux.
// A grant is held until ack, withdrawal of the granted request, or a hold
// timeout; on release the next requester is granted on the same edge.
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   req_i      [N-1:0] request per mux input
//   ack_i      consumer took the selected data (used only while valid)
//   sel_o      [SELW-1:0] registered select code, all ones when idle
//   valid_o    sel_o addresses a granted input
//   timeout_o  one-cycle pulse after a forced release
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; sel_o = idle code, waiting for any request
// GRANT | sel_o holds a granted input; watching ack/withdraw/timeout
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int N        = MUX_N,
    parameter int SELW     = MUX_SELW,
    parameter int HOLD_MAX = MUX_HOLD_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic            ack_i,
    output logic [SELW-1:0] sel_o,
    output logic            valid_o,
    output logic            timeout_o
);

    localparam int                CNTW      = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNTW-1:0]   CNT_LAST  = CNTW'(HOLD_MAX - 1);
    localparam logic [SELW-1:0]   SEL_IDLE_W = {SELW{1'b1}};

    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;

    logic            rel;
    logic            forced;
    logic [SELW-1:0] pick_ptr;
    logic            found;
    logic [SELW-1:0] idx;

    // Release decision depends only on registered state and inputs, so the
    // picker can use the post-release pointer without a combinational loop.
    always_comb begin
        rel    = 1'b0;
        forced = 1'b0;
        if (state_q == GRANT) begin
            if (ack_i) begin
                rel = 1'b1;
            end else if (!req_i[sel_q]) begin
                rel = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                rel    = 1'b1;
                forced = 1'b1;
            end
        end
    end

    assign pick_ptr = rel ? SELW'(ptr_inc(int'(sel_q), N)) : ptr_q;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (pick_ptr),
        .found_o (found),
        .idx_o   (idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d     = pick_ptr;
                    timeout_d = forced;
                    cnt_d     = '0;
                    if (found) begin
                        sel_d = idx;
                    end else begin
                        state_d = IDLE;
                        sel_d   = SEL_IDLE_W;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_IDLE_W;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= SEL_IDLE_W;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel_o     = sel_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Testbench for mux_sel_arbiter: directed scenarios with literal expectations
// followed by randomized traffic checked against a behavioural model.
module tb_mux_sel_arbiter;

    localparam int N         = 3;
    localparam int SELW      = 2;
    localparam int HOLD_MAX  = 8;
    localparam int IDLE_CODE = (1 << SELW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic            ack = 1'b0;
    logic [SELW-1:0] sel;
    logic            valid;
    logic            timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(
        .N        (N),
        .SELW     (SELW),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .ack_i     (ack),
        .sel_o     (sel),
        .valid_o   (valid),
        .timeout_o (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_held counts grant cycles completed-so-far including the current one.
    int m_ptr, m_sel, m_held;
    bit m_valid, m_to;

    function automatic int winner(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  w;
        bit  rel, forced;
        if (rst) begin
            m_ptr = 0; m_sel = 0; m_held = 0; m_valid = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_valid) begin
                w = winner(m_ptr, req);
                if (w >= 0) begin
                    m_valid = 1; m_sel = w; m_held = 1;
                end
            end else begin
                rel    = ack || !req[m_sel];
                forced = !rel && (m_held == HOLD_MAX);
                if (rel || forced) begin
                    m_ptr = (m_sel + 1) % N;
                    m_to  = forced;
                    w = winner(m_ptr, req);
                    if (w >= 0) begin
                        m_sel = w; m_held = 1;
                    end else begin
                        m_valid = 0;
                    end
                end else begin
                    m_held++;
                end
            end
        end
    end

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("model_valid", valid, m_valid);
            chk("model_sel", sel, m_valid ? m_sel : IDLE_CODE);
            chk("model_timeout", timeout, m_to);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic drive(input logic [N-1:0] r, input logic a);
        @(negedge clk);
        req = r;
        ack = a;
    endtask

    task automatic expect_out(input string name, input int s, input int v, input int t);
        @(posedge clk);
        #1;
        chk({name, "_sel"}, sel, s);
        chk({name, "_valid"}, valid, v);
        chk({name, "_timeout"}, timeout, t);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_sel", sel, IDLE_CODE);
        chk("reset_valid", valid, 0);
        chk("reset_timeout", timeout, 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // single requester, re-granted after its own ack
        drive(3'b010, 1'b0);
        expect_out("single_grant", 1, 1, 0);
        drive(3'b010, 1'b1);
        expect_out("single_regrant", 1, 1, 0);

        // asynchronous reset mid-grant
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        #1;
        chk("async_rst_sel", sel, IDLE_CODE);
        chk("async_rst_valid", valid, 0);
        chk("async_rst_timeout", timeout, 0);
        @(negedge clk);
        rst = 1'b0;

        // rotation from ptr=0 with continuous ack
        drive(3'b111, 1'b0);
        expect_out("rot0", 0, 1, 0);
        drive(3'b111, 1'b1);
        expect_out("rot1", 1, 1, 0);
        expect_out("rot2", 2, 1, 0);
        expect_out("rot3", 0, 1, 0);

        // wrap: release of 1 leaves ptr=2, search wraps to 0
        drive(3'b011, 1'b1);
        expect_out("wrap_a", 1, 1, 0);
        expect_out("wrap_b", 0, 1, 0);
        expect_out("wrap_c", 1, 1, 0);

        // withdraw
        drive(3'b100, 1'b0);
        expect_out("wd_grant2", 2, 1, 0);
        drive(3'b000, 1'b0);
        expect_out("wd_idle", IDLE_CODE, 0, 0);

        // timeout: ptr=0 after withdrawing 2
        drive(3'b101, 1'b0);
        expect_out("to_grant", 0, 1, 0);
        for (int i = 0; i < HOLD_MAX - 1; i++) begin
            expect_out("to_hold", 0, 1, 0);
        end
        expect_out("to_force", 2, 1, 1);
        expect_out("to_after", 2, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 5) == 0) req = N'($urandom);
            ack = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        ack = 1'b0;
        repeat (4) @(negedge clk);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
